clause_checker: RTL
===================

# clause_checker

Sequential evaluator that sits directly downstream of the static clause memory. On `start` it latches a full variable assignment, walks `row_ptr` across every clause-memory row, and evaluates `NUM_CLAUSES_PER_CYCLE` clauses per cycle against that assignment. It reports whether the formula is satisfied, how many clauses are unsatisfied, and the index of the first unsatisfied clause, for use by the search/flip controller.

## Interface
- `NUM_CLAUSES`, 64: total clauses; a multiple of `NUM_CLAUSES_PER_CYCLE`.
- `VAR_ID_BITS`, 8: literal variable-id width.
- `NUM_CLAUSES_PER_CYCLE`, 16: clauses per memory row.
- `NUM_VARS_PER_CLAUSE`, 3: literals per clause.
- `NUM_VARS`, 2**VAR_ID_BITS: assignment vector width.
- `PTR_BITS`, $clog2(NUM_CLAUSES/NUM_CLAUSES_PER_CYCLE): row pointer width.
- `clk  in  1`: the only clock.
- `rst  in  1`: reset, synchronous and active-high.
- `start  in  1`: request a scan; accepted only in IDLE.
- `assignment  in  NUM_VARS`: bit v is the value of variable v; sampled only on the accepting edge.
- `row_ptr  out  PTR_BITS`: row address to the clause memory.
- `memory_slice  in  ROW_WIDTH`: row data returned combinationally for `row_ptr`.
- `busy  out  1`: high in SCAN and DRAIN.
- `done  out  1`: one-cycle pulse when results are valid.
- `sat  out  1`: all clauses satisfied.
- `unsat_count  out  $clog2(NUM_CLAUSES+1)`: number of unsatisfied clauses.
- `first_unsat_valid  out  1`, `first_unsat_idx  out  $clog2(NUM_CLAUSES)`: lowest-index unsatisfied clause.

## Operation
- Literal encoding: literal k of clause c sits at bit offset c*CLAUSE_W + k*LIT_W, where LIT_W = VAR_ID_BITS+1 and CLAUSE_W = LIT_W*NUM_VARS_PER_CLAUSE.
  - Literal bit 0 is `neg`; bits [LIT_W-1:1] are `var_id`.
  - Variable ids start at 0.
- Literal value: `assignment_q[var_id] ^ neg`. If `var_id >= NUM_VARS`, the literal is false.
- A clause is satisfied when the OR of its literals is 1.
- Global clause index is row*NUM_CLAUSES_PER_CYCLE + c.
- FSM:
  - IDLE: on `start`, latch `assignment_q`, clear the accumulators, set `row_ptr`=0, go to SCAN.
  - SCAN: each edge, register the row's unsat mask and row index into the stage register.
    - If `row_ptr` == NUM_ROWS-1, go to DRAIN. Otherwise increment `row_ptr`.
  - DRAIN: fold the final stage register into the accumulators; pulse `done`; return to IDLE.
- Accumulate every cycle the stage register is valid:
  - `unsat_count` += popcount(mask). The count cannot overflow.
  - If `first_unsat_valid` is 0 and mask != 0, capture row*NUM_CLAUSES_PER_CYCLE + lowest set bit and set `first_unsat_valid`.
- `sat` = (`unsat_count` == 0) after the final fold.
- `start` is ignored while `busy`. Changes to `assignment` during a scan have no effect.
- Result outputs hold their values until the next accepted `start` clears them.

## Timing
- Reset values: state IDLE; `row_ptr`=0, `busy`=0, `done`=0, `sat`=0, `unsat_count`=0, `first_unsat_valid`=0, `first_unsat_idx`=0; stage register invalid.
- Edge E0 accepts `start`. `busy` is high from E0 through E(NUM_ROWS+1).
- `done` and valid results appear after edge E(NUM_ROWS+1): NUM_ROWS+1 edges of latency, which is 5 at default parameters. `busy` is low in that same cycle.
- `start` may be asserted in the cycle where `done` is high. That start is accepted, and the next scan begins back-to-back.
- Reset asserted mid-scan: on the next edge every output returns to its reset value, no `done` is produced, and the partial result is discarded.
- Memory read is combinational. `memory_slice` is treated as valid in the same cycle `row_ptr` is driven.

## Structure
- `sat_pkg` holds LIT_W, CLAUSE_W, and ROW_WIDTH as functions of the parameters, plus a `literal_t` packed struct `{var_id, neg}`.
- Sub-module `clause_eval`: combinational, one clause in plus `assignment_q`, outputs `unsat`. It is instantiated NUM_CLAUSES_PER_CYCLE times via generate.
- Popcount and priority-encode logic live inside `clause_checker`.

## Test plan
- All 64 clauses are (x0|x1|x2) positive, `assignment`=0 -> `done` 5 edges after start; `sat`=0, `unsat_count`=64, `first_unsat_idx`=0.
- Same memory, `assignment`[1]=1 -> `sat`=1, `unsat_count`=0, `first_unsat_valid`=0.
- Row 2 clause 5 = (¬x3|x4|x5), all other clauses satisfied by x0=1, with x3=1 and x4=x5=0 -> `unsat_count`=1, `first_unsat_idx`=37.
- `start` pulsed and `assignment` toggled during SCAN -> the second start is ignored, results match the latched assignment, and exactly one `done` pulse occurs.
- `rst` asserted in the second SCAN cycle -> all outputs return to reset values, no `done`; a following `start` completes normally.
- `NUM_VARS`=8, a clause containing var_id 9 positive plus two false literals -> that clause counts as unsatisfied.

Source files
------------

// File: rtl/sat_pkg.sv
// Shared literal/clause geometry for the clause checker and its clause evaluators.
package sat_pkg;

  localparam int DEF_VAR_ID_BITS       = 8;
  localparam int DEF_VARS_PER_CLAUSE   = 3;
  localparam int DEF_CLAUSES_PER_CYCLE = 16;

  function automatic int lit_w(input int var_id_bits);
    return var_id_bits + 1;
  endfunction

  function automatic int clause_w(input int var_id_bits, input int vars_per_clause);
    return lit_w(var_id_bits) * vars_per_clause;
  endfunction

  function automatic int row_width(input int var_id_bits, input int vars_per_clause,
                                   input int clauses_per_cycle);
    return clause_w(var_id_bits, vars_per_clause) * clauses_per_cycle;
  endfunction

  localparam int LIT_W     = lit_w(DEF_VAR_ID_BITS);
  localparam int CLAUSE_W  = clause_w(DEF_VAR_ID_BITS, DEF_VARS_PER_CLAUSE);
  localparam int ROW_WIDTH = row_width(DEF_VAR_ID_BITS, DEF_VARS_PER_CLAUSE,
                                       DEF_CLAUSES_PER_CYCLE);

  // neg occupies bit 0 of each literal, var_id the bits above it
  typedef struct packed {
    logic [DEF_VAR_ID_BITS-1:0] var_id;
    logic                       neg;
  } literal_t;

endpackage

// File: rtl/clause_eval.sv
// Combinational evaluation of one clause against the latched assignment.
module clause_eval
  import sat_pkg::*;
#(
  parameter int VAR_ID_BITS         = 8,
  parameter int NUM_VARS_PER_CLAUSE = 3,
  parameter int NUM_VARS            = 2**VAR_ID_BITS
) (
  input  logic [clause_w(VAR_ID_BITS, NUM_VARS_PER_CLAUSE)-1:0] clause,
  input  logic [NUM_VARS-1:0]                                  assignment_q,
  output logic                                                 unsat
);

  localparam int LW = lit_w(VAR_ID_BITS);

  logic [VAR_ID_BITS-1:0] var_id;
  logic                   neg;
  logic [NUM_VARS-1:0]    shifted;
  logic                   any_true;

  // Ids beyond the assignment width name no variable, so such literals are false
  always_comb begin
    any_true = 1'b0;
    var_id   = '0;
    neg      = 1'b0;
    shifted  = '0;
    for (int k = 0; k < NUM_VARS_PER_CLAUSE; k++) begin
      var_id  = clause[k*LW+1 +: VAR_ID_BITS];
      neg     = clause[k*LW];
      shifted = assignment_q >> var_id;
      if ((32'(var_id) < NUM_VARS) && (shifted[0] ^ neg)) begin
        any_true = 1'b1;
      end
    end
    unsat = ~any_true;
  end

endmodule

// File: rtl/clause_checker.sv
// Row-by-row clause scanner: counts unsatisfied clauses and finds the first one.
module clause_checker
  import sat_pkg::*;
#(
  parameter int NUM_CLAUSES           = 64,
  parameter int VAR_ID_BITS           = 8,
  parameter int NUM_CLAUSES_PER_CYCLE = 16,
  parameter int NUM_VARS_PER_CLAUSE   = 3,
  parameter int NUM_VARS              = 2**VAR_ID_BITS,
  parameter int PTR_BITS              = $clog2(NUM_CLAUSES/NUM_CLAUSES_PER_CYCLE)
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    start,
  input  logic [NUM_VARS-1:0]                     assignment,
  output logic [PTR_BITS-1:0]                     row_ptr,
  input  logic [row_width(VAR_ID_BITS, NUM_VARS_PER_CLAUSE,
                          NUM_CLAUSES_PER_CYCLE)-1:0] memory_slice,
  output logic                                    busy,
  output logic                                    done,
  output logic                                    sat,
  output logic [$clog2(NUM_CLAUSES+1)-1:0]        unsat_count,
  output logic                                    first_unsat_valid,
  output logic [$clog2(NUM_CLAUSES)-1:0]          first_unsat_idx
);

  localparam int NUM_ROWS = NUM_CLAUSES / NUM_CLAUSES_PER_CYCLE;
  localparam int NPC      = NUM_CLAUSES_PER_CYCLE;
  localparam int CW       = clause_w(VAR_ID_BITS, NUM_VARS_PER_CLAUSE);
  localparam int CNT_W    = $clog2(NUM_CLAUSES+1);
  localparam int IDX_W    = $clog2(NUM_CLAUSES);

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;

  state_t              state_q, state_d;
  logic [NUM_VARS-1:0] assignment_q, assignment_d;
  logic [PTR_BITS-1:0] row_ptr_q, row_ptr_d;
  logic                stage_valid_q, stage_valid_d;
  logic [NPC-1:0]      stage_mask_q, stage_mask_d;
  logic [PTR_BITS-1:0] stage_row_q, stage_row_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                sat_q, sat_d;
  logic [CNT_W-1:0]    unsat_count_q, unsat_count_d;
  logic                first_valid_q, first_valid_d;
  logic [IDX_W-1:0]    first_idx_q, first_idx_d;

  logic [NPC-1:0]      row_unsat;
  logic [CNT_W-1:0]    stage_pop;
  logic [IDX_W-1:0]    stage_first;
  logic [CNT_W-1:0]    fold_count;
  logic                fold_valid;
  logic [IDX_W-1:0]    fold_idx;

  for (genvar g = 0; g < NPC; g++) begin : g_eval
    clause_eval #(
      .VAR_ID_BITS        (VAR_ID_BITS),
      .NUM_VARS_PER_CLAUSE(NUM_VARS_PER_CLAUSE),
      .NUM_VARS           (NUM_VARS)
    ) u_eval (
      .clause      (memory_slice[g*CW +: CW]),
      .assignment_q(assignment_q),
      .unsat       (row_unsat[g])
    );
  end

  // Popcount and lowest-set-bit of the staged row mask, folded into the accumulators
  always_comb begin
    stage_pop   = '0;
    stage_first = '0;
    for (int i = 0; i < NPC; i++) begin
      stage_pop = stage_pop + CNT_W'(stage_mask_q[i]);
    end
    for (int i = NPC-1; i >= 0; i--) begin
      if (stage_mask_q[i]) begin
        stage_first = IDX_W'(32'(stage_row_q) * NPC + i);
      end
    end
    fold_count = unsat_count_q;
    fold_valid = first_valid_q;
    fold_idx   = first_idx_q;
    if (stage_valid_q) begin
      fold_count = unsat_count_q + stage_pop;
      if (!first_valid_q && (stage_mask_q != '0)) begin
        fold_valid = 1'b1;
        fold_idx   = stage_first;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    assignment_d  = assignment_q;
    row_ptr_d     = row_ptr_q;
    stage_valid_d = 1'b0;
    stage_mask_d  = stage_mask_q;
    stage_row_d   = stage_row_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    sat_d         = sat_q;
    unsat_count_d = fold_count;
    first_valid_d = fold_valid;
    first_idx_d   = fold_idx;
    case (state_q)
      IDLE: begin
        if (start) begin
          assignment_d  = assignment;
          row_ptr_d     = '0;
          busy_d        = 1'b1;
          sat_d         = 1'b0;
          unsat_count_d = '0;
          first_valid_d = 1'b0;
          first_idx_d   = '0;
          state_d       = SCAN;
        end
      end
      SCAN: begin
        stage_valid_d = 1'b1;
        stage_mask_d  = row_unsat;
        stage_row_d   = row_ptr_q;
        if (row_ptr_q == PTR_BITS'(NUM_ROWS-1)) begin
          state_d = DRAIN;
        end else begin
          row_ptr_d = row_ptr_q + PTR_BITS'(1);
        end
      end
      DRAIN: begin
        done_d    = 1'b1;
        busy_d    = 1'b0;
        sat_d     = (fold_count == '0);
        row_ptr_d = '0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      assignment_q  <= '0;
      row_ptr_q     <= '0;
      stage_valid_q <= 1'b0;
      stage_mask_q  <= '0;
      stage_row_q   <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      sat_q         <= 1'b0;
      unsat_count_q <= '0;
      first_valid_q <= 1'b0;
      first_idx_q   <= '0;
    end else begin
      state_q       <= state_d;
      assignment_q  <= assignment_d;
      row_ptr_q     <= row_ptr_d;
      stage_valid_q <= stage_valid_d;
      stage_mask_q  <= stage_mask_d;
      stage_row_q   <= stage_row_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      sat_q         <= sat_d;
      unsat_count_q <= unsat_count_d;
      first_valid_q <= first_valid_d;
      first_idx_q   <= first_idx_d;
    end
  end

  assign row_ptr           = row_ptr_q;
  assign busy              = busy_q;
  assign done              = done_q;
  assign sat               = sat_q;
  assign unsat_count       = unsat_count_q;
  assign first_unsat_valid = first_valid_q;
  assign first_unsat_idx   = first_idx_q;

endmodule
